mux2to1_stream: RTL and testbench
=================================

Name: mux2to1_stream

Overview:
- Merges two valid/ready data streams onto one output stream; the gathering counterpart to the team's 1-to-2 demux.
- A round-robin arbiter picks the source when both inputs present data. The winner's word lands in a registered output stage, tagged with its source index.
- Used where the demux-split paths rejoin, e.g. returning responses from two lanes to a single consumer.

Parameters:
- WIDTH, 4, data width in bits of each input and the output.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset; asserting it clears all state immediately, and state is released on the clock edge after deassertion.
- data_in0  input  WIDTH  source 0 data.
- valid_in0  input  1  source 0 data valid.
- ready_in0  output  1  source 0 accepted this cycle when high together with valid_in0.
- data_in1  input  WIDTH  source 1 data.
- valid_in1  input  1  source 1 data valid.
- ready_in1  output  1  source 1 handshake ready.
- data_out  output  WIDTH  registered merged data.
- valid_out  output  1  data_out holds a word.
- ready_out  input  1  downstream accepts data_out when high with valid_out.
- sel_out  output  1  source index of the word in data_out (0 or 1).

Behaviour:
- Reset values:
  - data_out=0, valid_out=0, sel_out=0.
  - The internal last_grant register resets to 1, so source 0 wins the first contention.
- Output stage is a one-entry pipeline register. can_load = !valid_out || ready_out.
- Grant logic is combinational from the valid inputs and last_grant:
  - only valid_in0 high: grant source 0.
  - only valid_in1 high: grant source 1.
  - both high: grant the source != last_grant.
  - neither high: no grant.
- ready_inN = can_load && (grant==N). The non-granted ready is 0.
- ready_in is independent of the same source's valid only through the grant. There is no combinational path from ready_out to data_out.
- On a handshake for source N:
  - data_out<=data_inN, sel_out<=N, valid_out<=1.
  - last_grant<=N.
- If valid_out && ready_out and no input handshakes: valid_out<=0. data_out and sel_out hold their last values.
- If valid_out && !ready_out (stall):
  - data_out, sel_out and valid_out stay stable.
  - Both ready_in are 0.
- Latency: 1 cycle from input handshake to valid_out.
- Throughput: one word per cycle when ready_out is held high.
- last_grant changes only on a completed input handshake. A valid that is withdrawn without a handshake does not affect fairness.
- Under sustained dual-valid traffic with ready_out=1, the sources alternate 0,1,0,1...
- Reset mid-transfer: the pending output word is discarded and valid_out drops asynchronously. After release, arbitration restarts with source 0 favoured.

Optional Feature:
- Macro: MUX2TO1_FIXED_PRIO_EN.
- Defined: fixed priority; source 0 always wins contention. The last_grant register is removed, and source 1 is served only when valid_in0=0.
- Undefined (default): round-robin as specified above.
- Ports and latency are identical in both builds.

Decomposition:
- Package mux2to1_pkg:
  - constants SRC0=1'b0, SRC1=1'b1.
  - localparam LAST_GRANT_RST=1'b1.
- Sub-module rr_arbiter2:
  - inputs: clk, rst_n, req[1:0], advance.
  - outputs: gnt[1:0] (one-hot or zero).
  - It owns last_grant and the MUX2TO1_FIXED_PRIO_EN switch.
- The top level holds the output register and the ready/handshake logic.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> valid_out=0, data_out=0, sel_out=0, ready_in0=ready_in1=1 only when the matching valid is high. Then release.
- Single source: valid_in1=1, data_in1=4'hA, ready_out=1 -> the next cycle gives data_out=4'hA, sel_out=1, valid_out=1. Source 0 is never granted.
- Contention: both valid with data_in0=4'h3, data_in1=4'h5, ready_out=1 for 4 cycles -> the output sequence is 3(sel0), 5(sel1), 3, 5. With MUX2TO1_FIXED_PRIO_EN defined, the sequence is 3,3,3,3.
- Backpressure: the output holds 4'h7, then ready_out=0 for 3 cycles -> data_out=4'h7 stable, ready_in0=ready_in1=0. The cycle after ready_out=1, the next word loads with no loss and no duplication.
- Bubble: input valid drops while ready_out=1 -> valid_out falls one cycle later. last_grant is unchanged, confirmed by the next contention order.
- Async reset mid-stall: pull rst_n low between clock edges while valid_out=1 -> valid_out=0 without waiting for a clock edge. The first contention after release grants source 0.

Source files
------------

// File: rtl/mux2to1_pkg.sv
// Shared constants for the 2-to-1 stream merge.
// Optional build macro MUX2TO1_FIXED_PRIO_EN (consumed in rr_arbiter2) selects
// fixed priority instead of round-robin.
package mux2to1_pkg;

  // Source indices as carried on sel_out and held in last_grant.
  localparam logic SRC0 = 1'b0;
  localparam logic SRC1 = 1'b1;

  // last_grant resets to source 1 so source 0 wins the first contention.
  localparam logic LAST_GRANT_RST = 1'b1;

  // Number of merged sources.
  localparam int unsigned NUM_SRC = 2;

  // Source index of a one-hot grant vector (zero grant maps to SRC0).
  function automatic logic gnt_to_idx(input logic [NUM_SRC-1:0] gnt);
    return gnt[1] ? SRC1 : SRC0;
  endfunction

endpackage

// File: rtl/mux2to1_stream_rr_arbiter2.sv
// Two-requester arbiter for mux2to1_stream.
// Build macro: MUX2TO1_FIXED_PRIO_EN
//   undefined : round-robin, last_grant register favours the other source
//   defined   : fixed priority, source 0 always wins, no state
// Ports:
//   clk, rst_n : clock, async active-low reset
//   req[1:0]   : request per source
//   advance    : a grant was consumed by a handshake this cycle
//   gnt[1:0]   : combinational one-hot grant, zero when no request
module rr_arbiter2
  import mux2to1_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_SRC-1:0]   req,
  input  logic                 advance,
  output logic [NUM_SRC-1:0]   gnt
);

`ifdef MUX2TO1_FIXED_PRIO_EN

  // Stateless build: clock, reset and advance are intentionally unused.
  logic unused_sigs;
  assign unused_sigs = ^{clk, rst_n, advance};

  // Source 0 always wins contention.
  always_comb begin
    gnt = '0;
    if (req[0]) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end
  end

`else

  logic last_grant;

  // Fairness state only moves on a completed handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= LAST_GRANT_RST;
    end else if (advance) begin
      last_grant <= gnt_to_idx(gnt);
    end
  end

  // On contention, grant the source that was not served last.
  always_comb begin
    gnt = '0;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_grant == SRC1) ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
  end

`endif

endmodule

// File: rtl/mux2to1_stream.sv
// Merges two valid/ready streams into one registered output stream.
// Build macro: MUX2TO1_FIXED_PRIO_EN (fixed priority instead of round-robin).
// Ports:
//   clk, rst_n                     : clock, async active-low reset
//   data_in0/valid_in0/ready_in0   : source 0 stream
//   data_in1/valid_in1/ready_in1   : source 1 stream
//   data_out/valid_out/ready_out   : merged output stream (registered)
//   sel_out                        : source index of the word in data_out
module mux2to1_stream
  import mux2to1_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in0,
  input  logic             valid_in0,
  output logic             ready_in0,
  input  logic [WIDTH-1:0] data_in1,
  input  logic             valid_in1,
  output logic             ready_in1,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  input  logic             ready_out,
  output logic             sel_out
);

  logic [NUM_SRC-1:0] gnt;
  logic               can_load;
  logic               advance;

  // Output register can accept a word when empty or being drained.
  assign can_load = !valid_out || ready_out;

  // A grant always implies the matching valid, so ready is the handshake.
  assign ready_in0 = can_load && gnt[0];
  assign ready_in1 = can_load && gnt[1];
  assign advance   = ready_in0 || ready_in1;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({valid_in1, valid_in0}),
    .advance (advance),
    .gnt     (gnt)
  );

  // One-entry output stage; data/sel hold their value after drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out  <= '0;
      sel_out   <= SRC0;
      valid_out <= 1'b0;
    end else if (advance) begin
      data_out  <= gnt[1] ? data_in1 : data_in0;
      sel_out   <= gnt_to_idx(gnt);
      valid_out <= 1'b1;
    end else if (ready_out) begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux2to1_stream.sv
// Scoreboard bench for mux2to1_stream: the driver predicts each accepted word
// from the arbitration rules and queues it; the monitor pops on output handshakes.
module tb_mux2to1_stream;

  localparam int unsigned WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] data_in0, data_in1, data_out;
  logic             valid_in0, valid_in1, ready_in0, ready_in1;
  logic             valid_out, ready_out, sel_out;

  always #5 clk = ~clk;

  mux2to1_stream #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in0  (data_in0),
    .valid_in0 (valid_in0),
    .ready_in0 (ready_in0),
    .data_in1  (data_in1),
    .valid_in1 (valid_in1),
    .ready_in1 (ready_in1),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .sel_out   (sel_out)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Expected output words in order: {sel, data}.
  logic [WIDTH:0] exp_q[$];
  // Reference state: output register occupied, and which source was served last.
  logic m_valid = 1'b0;
  int   m_last  = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, check readies against the rules, predict acceptance.
  task automatic drive(input logic v0, input logic [WIDTH-1:0] d0,
                       input logic v1, input logic [WIDTH-1:0] d1, input logic rdy);
    int   g;
    logic can;
    @(negedge clk);
    valid_in0 = v0; data_in0 = d0;
    valid_in1 = v1; data_in1 = d1;
    ready_out = rdy;
    #1;
    can = !m_valid || rdy;
    if (v0 && v1) begin
`ifdef MUX2TO1_FIXED_PRIO_EN
      g = 0;
`else
      g = 1 - m_last;
`endif
    end else if (v0) begin
      g = 0;
    end else if (v1) begin
      g = 1;
    end else begin
      g = -1;
    end
    chk("valid_out", 32'(valid_out), 32'(m_valid));
    chk("ready_in0", 32'(ready_in0), 32'(can && g == 0));
    chk("ready_in1", 32'(ready_in1), 32'(can && g == 1));
    if (rst_n && can && g >= 0) begin
      exp_q.push_back({(g == 1), ((g == 1) ? d1 : d0)});
      m_last  = g;
      m_valid = 1'b1;
    end else if (rst_n && rdy) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic drive_rand(input int rdy_pct);
    drive(1'($urandom_range(0, 1)), WIDTH'($urandom), 1'($urandom_range(0, 1)),
          WIDTH'($urandom), 1'($urandom_range(0, 99) < rdy_pct));
  endtask

  // Monitor: compare each word as it leaves on an output handshake.
  initial begin
    logic [WIDTH:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && valid_out && ready_out) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_word: got %0h sel %0d expected none at %0t",
                   data_out, sel_out, $time);
        end else begin
          e = exp_q.pop_front();
          chk("sb_data_out", 32'(data_out), 32'(e[WIDTH-1:0]));
          chk("sb_sel_out", 32'(sel_out), 32'(e[WIDTH]));
        end
      end
    end
  end

  initial begin
    int exp_seq[4];
    rst_n = 1'b0;
    valid_in0 = 1'b0; valid_in1 = 1'b0;
    data_in0 = '0; data_in1 = '0; ready_out = 1'b0;

    // Reset with random inputs: ready follows valid through the grant only.
    for (int i = 0; i < 4; i++) drive_rand(50);
    chk("rst_data_out", 32'(data_out), 32'h0);
    chk("rst_sel_out", 32'(sel_out), 32'h0);
    @(negedge clk);
    valid_in0 = 1'b0; valid_in1 = 1'b0;
    rst_n = 1'b1;

    // Single source 1.
    drive(1'b0, 4'h0, 1'b1, 4'hA, 1'b1);
    drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    chk("single_data", 32'(data_out), 32'hA);
    chk("single_sel", 32'(sel_out), 32'h1);

    // Contention for 4 cycles.
`ifdef MUX2TO1_FIXED_PRIO_EN
    exp_seq = '{3, 3, 3, 3};
`else
    exp_seq = '{3, 5, 3, 5};
`endif
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive(1'b1, 4'h3, 1'b1, 4'h5, 1'b1);
      else       drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
      if (i > 0) chk("contention_data", 32'(data_out), 32'(exp_seq[i-1]));
    end
    drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);

    // Backpressure: 7 held for 3 stalled cycles, then next word loads.
    drive(1'b1, 4'h7, 1'b0, 4'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'h8, 1'b1, 4'h9, 1'b0);
      chk("stall_data", 32'(data_out), 32'h7);
      chk("stall_ready0", 32'(ready_in0), 32'h0);
      chk("stall_ready1", 32'(ready_in1), 32'h0);
    end
    drive(1'b1, 4'h8, 1'b1, 4'h9, 1'b1);
    drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
`ifdef MUX2TO1_FIXED_PRIO_EN
    chk("after_stall_data", 32'(data_out), 32'h8);
`else
    chk("after_stall_data", 32'(data_out), 32'h9);
`endif
    drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);

    // Bubble: valid drops, fairness state kept.
    drive(1'b1, 4'h4, 1'b0, 4'h0, 1'b1);
    drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    chk("bubble_word", 32'(data_out), 32'h4);
    drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    chk("bubble_valid_low", 32'(valid_out), 32'h0);
    drive(1'b1, 4'h1, 1'b1, 4'h2, 1'b1);
    drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
`ifdef MUX2TO1_FIXED_PRIO_EN
    chk("bubble_next_sel", 32'(sel_out), 32'h0);
`else
    chk("bubble_next_sel", 32'(sel_out), 32'h1);
`endif
    drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);

    // Randomised traffic with backpressure.
    for (int i = 0; i < 400; i++) drive_rand(70);
    for (int i = 0; i < 3; i++) drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);

    // Async reset mid-stall.
    drive(1'b1, 4'h6, 1'b0, 4'h0, 1'b1);
    drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
    chk("pre_reset_valid", 32'(valid_out), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(valid_out), 32'h0);
    chk("async_rst_data", 32'(data_out), 32'h0);
    exp_q.delete();
    m_valid = 1'b0;
    m_last  = 1;
    for (int i = 0; i < 2; i++) drive_rand(50);
    @(negedge clk);
    valid_in0 = 1'b0; valid_in1 = 1'b0;
    rst_n = 1'b1;
    drive(1'b1, 4'h3, 1'b1, 4'h5, 1'b1);
    drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    chk("post_rst_data", 32'(data_out), 32'h3);
    chk("post_rst_sel", 32'(sel_out), 32'h0);

    for (int i = 0; i < 3; i++) drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
